seg_display: RTL and testbench
==============================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: Clock cycles each digit stays selected, legal range 2..2^20.
REQ-002 SHALL have port Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  32  value to show, taken from the WB stage display register output.
REQ-005 SHALL have port in_valid  input  1  one-cycle load strobe for in_data.
REQ-006 SHALL have port in_halt  input  1  CPU halted (exit syscall seen); level.
REQ-007 SHALL have port out_an  output  8  digit enables, active-low, one-hot-zero; bit i is digit i, digit 0 rightmost.
REQ-008 SHALL have port out_seg  output  8  segments, active-low; [6:0]={g,f,e,d,c,b,a}, [7]=dp.
REQ-009 SHALL have port out_busy  output  1  conversion in progress; constant 0 without the decimal feature.

Function
REQ-010 SHALL hold the shown value in an internal 32-bit register, loaded from in_data on the edge where in_valid=1 (hex mode).
REQ-011 SHALL run a prescaler 0..CLK_DIV-1; at terminal count the digit index (3 bits) increments, wrapping 7->0.
REQ-012 SHALL register out_an/out_seg, driving ~(1<<index) and the code for that digit one cycle after the index changes.
REQ-013 SHALL show, in hex mode, nibble [4i+3:4i] on digit i, without leading-zero blanking.
REQ-014 SHALL use hex codes (dp off) 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-015 SHALL drive dp low on digit 0 while in_halt=1; in_halt SHALL NOT stop scanning.
REQ-016 SHALL show a value loaded in cycle N on the next digit refresh after N; no partial or torn digits.

Reset
REQ-017 SHALL, while Reset=0, force out_an=FF, out_seg=FF, out_busy=0, prescaler=0, index=0, shown value=0 and the FSM to IDLE.
REQ-018 SHALL abort any conversion on reset and discard any pending value; no stale value SHALL appear after release.
REQ-019 SHALL drive digit 0 (out_an=FE) on the first edge after Reset rises.

Configuration
REQ-020 SHALL, with macro SEG_DISPLAY_DECIMAL_EN defined, show in_data as unsigned decimal instead of hex.
REQ-021 Decimal FSM: IDLE -(in_valid)-> SHIFT (32 double-dabble cycles into 40-bit BCD) -> DONE (1 cycle, shown value updated) -> IDLE, or -> SHIFT if a value is pending.
REQ-022 out_busy SHALL be 1 in SHIFT and DONE; the latency from accept to update is 33 cycles.
REQ-023 in_valid while busy SHALL go to a one-deep pending register; the latest value wins and nothing stalls.
REQ-024 SHALL, in decimal mode, show the low 8 BCD digits and light every dp when the value exceeds 99999999.
REQ-025 Without the macro, the module SHALL contain no FSM or BCD logic, out_busy SHALL be 0, and behaviour SHALL match REQ-010..016.

Structure
REQ-026 Package seg_pkg SHALL hold the 16-entry segment table, the dp bit index, the FSM state enum and the CLK_DIV default.
REQ-027 The conversion SHALL be sub-module seg_bin2bcd (start/value in, busy/done/40-bit BCD out), instantiated only under SEG_DISPLAY_DECIMAL_EN.

Verification (CLK_DIV=4)
REQ-028 Hold Reset=0, then release it -> out_an=FF and out_seg=FF while held; out_an=FE on the first edge after release.
REQ-029 Free-run the scan -> out_an steps FE,FD,FB..7F every 4 cycles and returns to FE after 32 cycles.
REQ-030 Hex, in_valid with in_data=0000001F -> digit0=8E, digit1=F9, digits 2..7=C0; set in_halt=1 -> digit0=0E.
REQ-031 Decimal, load 1234 -> out_busy high for 33 cycles, then digits 0..3 = 99,B0,A4,F9 and the rest C0.
REQ-032 Decimal, load 5 then 7 at cycle 10 of busy -> 5 is shown, a second conversion starts, and 7 is shown 33 cycles after DONE.
REQ-033 Decimal, load FFFFFFFF -> digits read 94967295 with all dp low; assert Reset mid-SHIFT -> out_busy=0 and the shown value is 0.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seg_display scanner
// Purpose: segment lookup table, dp bit position, decimal-converter state
//          enum and the default scan divider.
// Ports:   none (package).
package seg_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 50000;

  // Position of the decimal point inside an out_seg byte.
  localparam int unsigned DP_BIT = 7;

  // Active-low {dp,g,f,e,d,c,b,a} codes with dp off, indexed by nibble 0..F.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_bin2bcd.sv
// rtl/seg_bin2bcd.sv - sequential 32-bit binary to 10-digit BCD converter
// Purpose: double-dabble, one bit per cycle. IDLE -> SHIFT (32 cycles) ->
//          DONE (1 cycle, bcd valid) -> IDLE, or straight back to SHIFT when
//          start is asserted during DONE.
// Ports:   clk, rst_n (async, active-low)
//          start  - accept value (honoured in IDLE and DONE)
//          value  - 32-bit binary input
//          busy   - high in SHIFT and DONE
//          done   - high for the single DONE cycle
//          bcd    - 40-bit packed BCD result, stable while done=1
module seg_bin2bcd
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);

  seg_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [39:0] adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    adj     = '0;

    // Add-3 correction on every digit >= 5 before the shift.
    for (int i = 0; i < 10; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                 : bcd_q[4*i +: 4];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // Top digit never exceeds 4 after correction, so adj[39] is always 0.
        {bcd_d, bin_d} = {adj[38:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display.sv
// rtl/seg_display.sv - 8-digit multiplexed seven-segment display driver
// Purpose: scans 8 digits, CLK_DIV cycles per digit, showing a 32-bit value
//          in hex, or in unsigned decimal when SEG_DISPLAY_DECIMAL_EN is
//          defined. Digit outputs only change on a digit refresh, so a new
//          value never tears a digit mid-dwell.
// Ports:   Clock    - system clock
//          Reset    - async, active-low
//          in_data  - value to display
//          in_valid - one-cycle load strobe
//          in_halt  - level, lights dp on digit 0
//          out_an   - active-low digit enables (bit 0 = rightmost)
//          out_seg  - active-low segments {dp,g,f,e,d,c,b,a}
//          out_busy - decimal conversion in progress (0 in hex build)
// Macro:   SEG_DISPLAY_DECIMAL_EN
module seg_display
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_halt,
  output logic [7:0]  out_an,
  output logic [7:0]  out_seg,
  output logic        out_busy
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          refresh_q, refresh_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [31:0]   val_q, val_d;
  logic          tc;
  logic          dp_all;

  // Scan path: refresh_q marks the first cycle of a digit (and the first
  // cycle after reset) so that the outputs lag the index by one cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      refresh_q <= 1'b1;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
      val_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      refresh_q <= refresh_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      val_q     <= val_d;
    end
  end

  always_comb begin
    tc        = (presc_q == PW'(CLK_DIV - 1));
    presc_d   = tc ? '0 : presc_q + 1'b1;
    idx_d     = tc ? idx_q + 3'd1 : idx_q;
    refresh_d = tc;
    an_d      = an_q;
    seg_d     = seg_q;
    if (refresh_q) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = SEG_TABLE[val_q[{idx_q, 2'b00} +: 4]];
      if (dp_all) seg_d[DP_BIT] = 1'b0;
      if (in_halt && (idx_q == 3'd0)) seg_d[DP_BIT] = 1'b0;
    end
  end

`ifdef SEG_DISPLAY_DECIMAL_EN
  // val_q holds 8 BCD digits; dp_all_q flags values above 99999999.
  logic        dp_all_q, dp_all_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_q, pend_d;
  logic        conv_start;
  logic [31:0] conv_value;
  logic        conv_busy;
  logic        conv_done;
  logic [39:0] conv_bcd;

  seg_bin2bcd u_bin2bcd (
    .clk   (Clock),
    .rst_n (Reset),
    .start (conv_start),
    .value (conv_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dp_all_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      dp_all_q <= dp_all_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    // A fresh strobe always beats the pending value (latest wins). The
    // converter restarts directly from DONE, so back-to-back loads never idle.
    conv_start = (in_valid || pend_v_q) && (!conv_busy || conv_done);
    conv_value = in_valid ? in_data : pend_q;
    pend_v_d   = pend_v_q;
    pend_d     = pend_q;
    if (conv_start) begin
      pend_v_d = 1'b0;
    end else if (in_valid) begin
      pend_v_d = 1'b1;
      pend_d   = in_data;
    end
    val_d    = val_q;
    dp_all_d = dp_all_q;
    if (conv_done) begin
      val_d    = conv_bcd[31:0];
      dp_all_d = |conv_bcd[39:32];
    end
  end

  assign dp_all   = dp_all_q;
  assign out_busy = conv_busy;
`else
  always_comb begin
    val_d = in_valid ? in_data : val_q;
  end

  assign dp_all   = 1'b0;
  assign out_busy = 1'b0;
`endif

  assign out_an  = an_q;
  assign out_seg = seg_q;

endmodule

// File: tb/tb_seg_display.sv
// tb/tb_seg_display.sv - self-checking bench for seg_display (CLK_DIV=4)
module tb_seg_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_halt = 1'b0;
  logic [7:0]  out_an;
  logic [7:0]  out_seg;
  logic        out_busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [7:0] cap_seg  [8];
  bit         cap_seen [8];

  seg_display #(.CLK_DIV(4)) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_halt  (in_halt),
    .out_an   (out_an),
    .out_seg  (out_seg),
    .out_busy (out_busy)
  );

  always #5 clk = ~clk;

  // Expected segment byte for digit i of value v, straight from the display rules.
  function automatic logic [7:0] model_code(input logic [31:0] v, input int i, input bit halt);
    logic [7:0] c;
    longint unsigned vv;
    longint unsigned p;
    int d;
    vv = v;
`ifdef SEG_DISPLAY_DECIMAL_EN
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    d = int'((vv / p) % 10);
    c = hex_tab[d];
    if (vv > 64'd99999999) c[7] = 1'b0;
`else
    p = 0;
    d = int'((vv >> (4 * i)) & 15);
    c = hex_tab[d];
`endif
    if (halt && i == 0) c[7] = 1'b0;
    return c;
  endfunction

  task automatic load(input logic [31:0] v);
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sample one full scan and remember the byte seen under each digit enable.
  task automatic capture();
    for (int i = 0; i < 8; i++) cap_seen[i] = 1'b0;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (out_an === ~(8'd1 << i)) begin
          cap_seg[i]  = out_seg;
          cap_seen[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=FF", out_an); end
      checks++;
      if (out_seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=FF", out_seg); end
      checks++;
      if (out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_an !== 8'hFE) begin failures++; $display("FAIL release_an got=%h exp=FE", out_an); end
    checks++;
    if (out_seg !== 8'hC0) begin failures++; $display("FAIL release_seg got=%h exp=C0", out_seg); end
  endtask

  // Continues counting edges from the first edge after release.
  task automatic test_scan();
    logic [7:0] exp_an;
    for (int k = 2; k <= 66; k++) begin
      @(posedge clk);
      #1;
      exp_an = ~(8'd1 << (((k - 1) / 4) % 8));
      checks++;
      if (out_an !== exp_an) begin
        failures++;
        $display("FAIL scan_an edge=%0d got=%h exp=%h", k, out_an, exp_an);
      end
    end
  endtask

  task automatic test_display();
    logic [31:0] vals  [11];
    bit          halts [11];
    logic [7:0]  e;
    vals[0] = 32'h0000001F; halts[0] = 1'b0;
    vals[1] = 32'h0000001F; halts[1] = 1'b1;
    vals[2] = 32'hFFFFFFFF; halts[2] = 1'b0;
    vals[3] = 32'd1234;     halts[3] = 1'b0;
    vals[4] = 32'd0;        halts[4] = 1'b1;
    for (int n = 5; n < 11; n++) begin
      vals[n]  = $urandom;
      halts[n] = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < 11; n++) begin
      in_halt = halts[n];
      load(vals[n]);
      repeat (80) @(negedge clk);
      capture();
      for (int i = 0; i < 8; i++) begin
        e = model_code(vals[n], i, halts[n]);
        checks++;
        if (!cap_seen[i] || cap_seg[i] !== e) begin
          failures++;
          $display("FAIL display val=%h halt=%0d digit=%0d seen=%0d got=%h exp=%h",
                   vals[n], halts[n], i, cap_seen[i], cap_seg[i], e);
        end
      end
    end
    in_halt = 1'b0;
`ifndef SEG_DISPLAY_DECIMAL_EN
    checks++;
    if (out_busy !== 1'b0) begin failures++; $display("FAIL hex_busy got=%b exp=0", out_busy); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  e;
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    in_data  = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (120) @(negedge clk);
    capture();
    for (int i = 0; i < 8; i++) begin
      e = model_code(b, i, 1'b0);
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== e) begin
        failures++;
        $display("FAIL back_to_back digit=%0d got=%h exp=%h", i, cap_seg[i], e);
      end
    end
  endtask

`ifdef SEG_DISPLAY_DECIMAL_EN
  task automatic test_busy();
    int cnt;
    logic [7:0] e;
    load(32'd1234);
    cnt = 0;
    while (out_busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 33) begin failures++; $display("FAIL busy_len got=%0d exp=33", cnt); end
    repeat (40) @(negedge clk);
    capture();
    for (int i = 0; i < 8; i++) begin
      e = model_code(32'd1234, i, 1'b0);
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== e) begin
        failures++;
        $display("FAIL busy_display digit=%0d got=%h exp=%h", i, cap_seg[i], e);
      end
    end
  endtask

  task automatic test_pending();
    int cnt;
    logic [7:0] e;
    load(32'd5);
    cnt = 0;
    while (out_busy === 1'b1 && cnt < 200) begin
      cnt++;
      in_data  = 32'd7;
      in_valid = (cnt == 10);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (cnt != 66) begin failures++; $display("FAIL pending_busy_len got=%0d exp=66", cnt); end
    repeat (40) @(negedge clk);
    capture();
    for (int i = 0; i < 8; i++) begin
      e = model_code(32'd7, i, 1'b0);
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== e) begin
        failures++;
        $display("FAIL pending_display digit=%0d got=%h exp=%h", i, cap_seg[i], e);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] e;
    load(32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", out_busy); end
    checks++;
    if (out_an !== 8'hFF) begin failures++; $display("FAIL mid_reset_an got=%h exp=FF", out_an); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checks++;
    if (out_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", out_busy); end
    capture();
    for (int i = 0; i < 8; i++) begin
      e = model_code(32'd0, i, 1'b0);
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== e) begin
        failures++;
        $display("FAIL post_reset_display digit=%0d got=%h exp=%h", i, cap_seg[i], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_display();
    test_back_to_back();
`ifdef SEG_DISPLAY_DECIMAL_EN
    test_busy();
    test_pending();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
